// File: rtl/maze_engine_param.sv
// Maze game core: player position, rate-limited wall-checked moves, win/fail detection
// and a per-pixel renderer for the OLED mux (one CLK of render latency).
module maze_engine_param #(
  parameter int          GRID_W     = 18,
  parameter int          GRID_H     = 11,
  parameter int          CELL_PX    = 5,
  parameter int          ORIGIN_X   = 3,
  parameter int          ORIGIN_Y   = 4,
  parameter int          MOVE_LIMIT = 255,
  parameter logic [15:0] WALL_RGB   = 16'hFFFF,
  parameter logic [15:0] PATH_RGB   = 16'h0000,
  parameter logic [15:0] PLAYER_RGB = 16'hF800,
  parameter logic [15:0] GOAL_RGB   = 16'h07E0,
  localparam int NCELL = GRID_W * GRID_H,
  localparam int IDXW  = (NCELL > 1) ? $clog2(NCELL) : 1,
  localparam int RW    = (GRID_H > 1) ? $clog2(GRID_H) : 1,
  localparam int CW    = (GRID_W > 1) ? $clog2(GRID_W) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             tick,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_centre,
  input  logic             pausesw,
  input  logic [NCELL-1:0] maze_walls,
  input  logic [IDXW-1:0]  start_cell,
  input  logic [IDXW-1:0]  goal_cell,
  input  logic [2:0]       curr_colour,
  input  logic [6:0]       x,
  input  logic [5:0]       y,
  output logic [15:0]      oled_data,
  output logic [IDXW-1:0]  player_cell,
  output logic [15:0]      move_count,
  output logic [2:0]       state,
  output logic [2:0]       wire_to_cut
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_PAUSED = 3'd2,
    S_WON    = 3'd3,
    S_FAILED = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] player_q, player_d;
  logic [15:0]     count_q, count_d;
  logic [2:0]      wire_q, wire_d;
  logic            blink_q;
  logic [15:0]     oled_q, pix_d;

  logic [RW-1:0]   p_row, t_row;
  logic [CW-1:0]   p_col, t_col;
  logic            dir_valid, at_edge, move_ok;
  logic [IDXW-1:0] tgt_idx;
  logic [15:0]     count_inc;

  // Move decode: only the highest-priority pressed direction is considered.
  always_comb begin
    p_row     = RW'(32'(player_q) / 32'(GRID_W));
    p_col     = CW'(32'(player_q) % 32'(GRID_W));
    t_row     = p_row;
    t_col     = p_col;
    dir_valid = 1'b1;
    at_edge   = 1'b0;
    if (btn_up) begin
      at_edge = (p_row == '0);
      t_row   = p_row - RW'(1);
    end else if (btn_down) begin
      at_edge = (p_row == RW'(GRID_H - 1));
      t_row   = p_row + RW'(1);
    end else if (btn_left) begin
      at_edge = (p_col == '0);
      t_col   = p_col - CW'(1);
    end else if (btn_right) begin
      at_edge = (p_col == CW'(GRID_W - 1));
      t_col   = p_col + CW'(1);
    end else begin
      dir_valid = 1'b0;
    end
    tgt_idx   = IDXW'(32'(t_row) * 32'(GRID_W) + 32'(t_col));
    move_ok   = dir_valid && !at_edge && !maze_walls[tgt_idx];
    count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      player_q <= '0;
      count_q  <= '0;
      wire_q   <= '0;
      blink_q  <= 1'b0;
      oled_q   <= PATH_RGB;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      count_q  <= count_d;
      wire_q   <= wire_d;
      oled_q   <= pix_d;
      if (tick) begin
        blink_q <= ~blink_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    count_d  = count_q;
    wire_d   = wire_q;
    case (state_q)
      S_IDLE: begin
        player_d = start_cell;
        if (tick && btn_centre) begin
          state_d = S_PLAY;
          count_d = '0;
        end
      end
      S_PLAY: begin
        // Pause wins over a move requested in the same cycle.
        if (pausesw) begin
          state_d = S_PAUSED;
        end else if (tick && move_ok) begin
          player_d = tgt_idx;
          count_d  = count_inc;
          if (tgt_idx == goal_cell) begin
            state_d = S_WON;
            wire_d  = curr_colour;
          end else if (count_inc >= 16'(MOVE_LIMIT)) begin
            state_d = S_FAILED;
          end
        end
      end
      S_PAUSED: begin
        if (!pausesw) begin
          state_d = S_PLAY;
        end
      end
      S_WON, S_FAILED: begin
        if (tick && btn_centre) begin
          state_d = S_IDLE;
          wire_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [31:0]     rx, ry;
  logic            in_grid;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [IDXW-1:0] r_idx;

  always_comb begin
    rx      = 32'(x) - 32'(ORIGIN_X);
    ry      = 32'(y) - 32'(ORIGIN_Y);
    in_grid = (32'(x) >= 32'(ORIGIN_X)) && (32'(y) >= 32'(ORIGIN_Y)) &&
              (rx / 32'(CELL_PX) < 32'(GRID_W)) && (ry / 32'(CELL_PX) < 32'(GRID_H));
    r_col   = CW'(rx / 32'(CELL_PX));
    r_row   = RW'(ry / 32'(CELL_PX));
    r_idx   = IDXW'(32'(r_row) * 32'(GRID_W) + 32'(r_col));
    pix_d   = PATH_RGB;
    if (in_grid) begin
      if (r_idx == player_q) begin
        pix_d = (state_q == S_FAILED && !blink_q) ? PATH_RGB : PLAYER_RGB;
      end else if (r_idx == goal_cell) begin
        pix_d = GOAL_RGB;
      end else if (maze_walls[r_idx]) begin
        pix_d = WALL_RGB;
      end
    end
  end

  assign oled_data   = oled_q;
  assign player_cell = player_q;
  assign move_count  = count_q;
  assign state       = state_q;
  assign wire_to_cut = wire_q;

endmodule

// File: doc/maze_engine_param.md
Name: maze_engine_param

Overview:
- Parametrised maze game core: grid size, cell pixel size, screen origin and colours are all configurable.
- Holds the player position; applies rate-limited, wall-checked moves; counts moves; detects win and move-limit failure.
- Supports pause.
- Renders the maze, player and goal per OLED pixel coordinate, and reports the wire colour to cut on a win.
- Sits between the debounced push-buttons and the OLED pixel mux of the wire-cutting game.

Parameters:
- GRID_W, 18, maze columns.
- GRID_H, 11, maze rows.
- CELL_PX, 5, pixel edge length of one cell.
- ORIGIN_X, 3, screen x of the left edge of column 0.
- ORIGIN_Y, 4, screen y of the top edge of row 0.
- MOVE_LIMIT, 255, successful moves allowed before failure (1..65535).
- WALL_RGB, 16'hFFFF, wall colour.
- PATH_RGB, 16'h0000, path and background colour.
- PLAYER_RGB, 16'hF800, player colour.
- GOAL_RGB, 16'h07E0, goal colour.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- tick  in  1  one-CLK-wide move-rate enable (10 Hz strobe).
- btn_up, btn_down, btn_left, btn_right, btn_centre  in  1 each  debounced button levels.
- pausesw  in  1  pause switch.
- maze_walls  in  GRID_W*GRID_H  wall bitmap; bit (row*GRID_W+col) = 1 means wall.
- start_cell  in  IDXW  start index; IDXW = clog2(GRID_W*GRID_H).
- goal_cell  in  IDXW  goal index.
- curr_colour  in  3  colour of the wire tied to this maze.
- x  in  7  OLED pixel column.
- y  in  6  OLED pixel row.
- oled_data  out  16  RGB565 pixel.
- player_cell  out  IDXW  current player index.
- move_count  out  16  successful moves this round.
- state  out  3  0 IDLE, 1 PLAY, 2 PAUSED, 3 WON, 4 FAILED.
- wire_to_cut  out  3  latched curr_colour on win; 0 otherwise.

Behaviour:
- Reset values (asynchronous): state = IDLE; player_cell = 0; move_count = 0; wire_to_cut = 0; oled_data = PATH_RGB.
- IDLE:
  - player_cell tracks start_cell every cycle.
  - btn_centre high on a tick: go to PLAY, clear move_count.
- PLAY:
  - Only tick cycles act; at most one move per tick.
  - Direction priority is up > down > left > right; lower-priority buttons are ignored that tick.
  - Up = row-1, down = row+1, left = col-1, right = col+1.
  - A move is blocked when the target leaves the grid (row 0 up, row GRID_H-1 down, col 0 left, col GRID_W-1 right) or the target wall bit is 1.
  - No wrap-around.
  - A blocked move changes nothing and is not counted.
- Successful move:
  - player_cell updates; move_count increments and saturates at 16'hFFFF.
  - If the new cell equals goal_cell: state = WON, wire_to_cut = curr_colour sampled that cycle. This takes priority over failure.
  - Otherwise, if move_count reaches MOVE_LIMIT: state = FAILED.
- Pause:
  - pausesw high in PLAY moves to PAUSED on the next CLK edge, independent of tick.
  - PAUSED ignores buttons; pausesw low returns to PLAY.
  - pausesw is ignored in IDLE, WON and FAILED.
- WON / FAILED:
  - Position and count are frozen.
  - btn_centre on a tick returns to IDLE and clears wire_to_cut.
  - wire_to_cut stays 0 in FAILED.
- start_cell == goal_cell: the first successful move away is a normal move; a win needs re-entry to the goal.
- RESET asserted mid-round returns everything to reset values immediately.
- Rendering (registered, 1 CLK latency from x/y):
  - col = (x-ORIGIN_X)/CELL_PX, row = (y-ORIGIN_Y)/CELL_PX.
  - Pixels outside the grid rectangle output PATH_RGB.
  - Precedence: player cell PLAYER_RGB > goal cell GOAL_RGB > wall WALL_RGB > PATH_RGB.
  - In FAILED, the player cell blinks: PLAYER_RGB on odd move_count-independent tick count, PATH_RGB otherwise, toggled by an internal 1-bit tick toggle.
- Width rules: row/col arithmetic uses widths clog2(GRID_H) and clog2(GRID_W); index = row*GRID_W+col, truncated to IDXW.

Test Plan:
- Reset, then btn_centre on tick with start_cell=0 -> state=1, player_cell=0, move_count=0.
- Open grid, player at index 0, btn_up and btn_left on ticks -> player_cell stays 0, move_count=0 (edge blocked). Then btn_right held for 3 ticks -> player_cell=3, move_count=3.
- Wall at index 19 (GRID_W=18), player at 1, btn_down on tick -> blocked, player_cell=1. btn_up+btn_down+btn_right together -> only up considered, blocked, no change.
- goal_cell=2, player at 1, curr_colour=3'b101, btn_right tick -> state=3, wire_to_cut=3'b101. Further buttons -> no change. btn_centre tick -> state=0, wire_to_cut=0.
- MOVE_LIMIT=4, wander without goal -> state=4 after 4th move, wire_to_cut=0. Variant: goal reached on 4th move -> state=3.
- pausesw high in PLAY -> state=2; btn_right tick -> no move; pausesw low -> state=1. Render check: x,y at player cell pixel -> oled_data=16'hF800 one CLK later; outside grid -> 16'h0000.
